rgb_compress_arbiter: RTL

Shares one `rgb_compress` instance among `NUM_SOURCES` marker-detect pixel streams. Grants the compressor for whole groups of `AVERAGE_OVER` consecutive pixels, chosen round-robin, with back-to-back groups and no idle cycles. Returns each 3-bit compressed result tagged with its source index. Sits between the per-target pixel fetchers and the single shared compressor in `marker_detect`.

---
 rtl/marker_detect_pkg.sv | 16 +
 rtl/rr_pick.sv | 31 +++
 rtl/rgb_compress_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/marker_detect_pkg.sv
// Shared types and helpers for the marker_detect pixel path.
package marker_detect_pkg;

    localparam int DEFAULT_COLOUR_DEPTH = 8;

    typedef logic [3*DEFAULT_COLOUR_DEPTH-1:0] rgb_t;
    typedef logic [2:0]                        compressed_t;

    localparam logic ARB_IDLE = 1'b0;
    localparam logic ARB_FEED = 1'b1;

    function automatic int src_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester after `last`, wrapping around,
// so `last` itself only wins when it is the sole requester.
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         valid,
    output logic [W-1:0] idx
);

    int           cand;
    logic [N-1:0] shifted;

    // Walk candidates from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        valid   = |req;
        idx     = '0;
        cand    = 0;
        shifted = '0;
        for (int k = N; k >= 1; k--) begin
            cand    = (int'(last) + k) % N;
            shifted = req >> cand;
            if (shifted[0]) begin
                idx = W'(cand);
            end
        end
    end

endmodule

// File: rtl/rgb_compress_arbiter.sv
// Time-shares one rgb_compress among NUM_SOURCES pixel streams, one AVERAGE_OVER-pixel
// group per grant, and tags each compressed result with the source that produced it.
module rgb_compress_arbiter
    import marker_detect_pkg::*;
#(
    parameter int NUM_SOURCES      = 7,
    parameter int COLOUR_DEPTH     = 8,
    parameter int AVERAGE_OVER     = 3,
    parameter int COMPRESS_LATENCY = 1
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic [NUM_SOURCES-1:0]                req_in,
    input  logic [NUM_SOURCES*3*COLOUR_DEPTH-1:0] rgb_in,
    output logic [NUM_SOURCES-1:0]                pop_out,
    output logic [3*COLOUR_DEPTH-1:0]             comp_rgb_out,
    output logic                                  comp_valid_out,
    output logic                                  comp_start_out,
    input  logic [2:0]                            comp_result_in,
    output logic [2:0]                            result_out,
    output logic                                  result_valid_out,
    output logic [$clog2(NUM_SOURCES)-1:0]        result_src_out,
    output logic                                  busy_out
);

    localparam int RGB_W  = 3 * COLOUR_DEPTH;
    localparam int IDX_W  = src_idx_w(NUM_SOURCES);
    localparam int BEAT_W = src_idx_w(AVERAGE_OVER);
    localparam int TAG_W  = COMPRESS_LATENCY * IDX_W;

    logic                        state;
    logic [IDX_W-1:0]            grant;
    logic [IDX_W-1:0]            last_grant;
    logic [IDX_W-1:0]            pick_last;
    logic [IDX_W-1:0]            pick_idx;
    logic                        pick_valid;
    logic [BEAT_W-1:0]           beat;
    logic                        last_beat;
    logic [COMPRESS_LATENCY-1:0] tag_valid;
    logic [TAG_W-1:0]            tag_idx;
    logic [NUM_SOURCES*RGB_W-1:0] rgb_shifted;
    compressed_t                 result_q;

    // A back-to-back pick must treat the source finishing now as the one just served.
    assign pick_last = (state == ARB_FEED) ? grant : last_grant;
    assign last_beat = (state == ARB_FEED) && (beat == BEAT_W'(AVERAGE_OVER - 1));

    rr_pick #(
        .N (NUM_SOURCES),
        .W (IDX_W)
    ) u_pick (
        .req   (req_in),
        .last  (pick_last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        pop_out        = '0;
        comp_valid_out = 1'b0;
        comp_start_out = 1'b0;
        rgb_shifted    = rgb_in;
        if (state == ARB_FEED) begin
            pop_out        = {{(NUM_SOURCES-1){1'b0}}, 1'b1} << grant;
            comp_valid_out = 1'b1;
            comp_start_out = (beat == '0);
            rgb_shifted    = rgb_in >> (int'(grant) * RGB_W);
        end
        comp_rgb_out = rgb_shifted[RGB_W-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= ARB_IDLE;
            beat       <= '0;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_SOURCES - 1);
        end else if (state == ARB_IDLE) begin
            if (pick_valid) begin
                grant <= pick_idx;
                beat  <= '0;
                state <= ARB_FEED;
            end
        end else if (last_beat) begin
            last_grant <= grant;
            beat       <= '0;
            if (pick_valid) begin
                grant <= pick_idx;
            end else begin
                state <= ARB_IDLE;
            end
        end else begin
            beat <= beat + 1'b1;
        end
    end

    // The tag pipeline mirrors the compressor latency so each result meets its source index.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tag_valid        <= '0;
            tag_idx          <= '0;
            result_q         <= '0;
            result_src_out   <= '0;
            result_valid_out <= 1'b0;
        end else begin
            tag_valid        <= (tag_valid << 1) | COMPRESS_LATENCY'(last_beat);
            tag_idx          <= (tag_idx << IDX_W) | TAG_W'(grant);
            result_valid_out <= tag_valid[COMPRESS_LATENCY-1];
            if (tag_valid[COMPRESS_LATENCY-1]) begin
                result_q       <= comp_result_in;
                result_src_out <= tag_idx[TAG_W-1 -: IDX_W];
            end
        end
    end

    assign result_out = result_q;
    assign busy_out   = (state != ARB_IDLE) || (|tag_valid);

endmodule
